mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the multi-cycle MIPS datapath. It sits directly downstream of the control unit, which drives operation select, start strobe and move-to-HI/LO. Operands come from the GPR A/B latches. HI/LO results feed the MemtoReg mux, and `Ready_O` gates the MFHI/MFLO wait state.

## Interface
Parameters:
- `MUL_LAT`, default 5: cycles from start capture to multiply result commit (≥1).

Ports:
- `clk_I`  in  1  clock, all state updates on rising edge.
- `rst_I`  in  1  reset, asynchronous, active-high.
- `MDOp_I`  in  3  operation select: 000 OFF, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU (shared-header `MDOP_*` values).
- `MDCTRL_I`  in  1  start strobe. 1 = `MDCTRL_ON`.
- `MT_I`  in  2  move-to select: 00 OFF, 01 HI, 10 LO (shared-header `MT_*`).
- `A_I`  in  32  GPR A latch: multiplicand, dividend, or MTHI/MTLO data.
- `B_I`  in  32  GPR B latch: multiplier or divisor.
- `HI_O`  out  32  HI register.
- `LO_O`  out  32  LO register.
- `Ready_O`  out  1  1 = idle and HI/LO valid.
- `Busy_O`  out  1  complement of `Ready_O`. Registered.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset values: HI_O=0, LO_O=0, Ready_O=1, Busy_O=0, state IDLE, counter 0.
- Start in IDLE when MDCTRL_I=1 and MDOp_I≠OFF:
  - Latch A_I and B_I.
  - Clear the counter.
  - Go to MUL or DIV.
- MUL:
  - Product is 64 bits: signed×signed for MULT, unsigned for MULTU.
  - Hold the product in a pending register.
  - Count to MUL_LAT, then commit HI←product[63:32], LO←product[31:0] and return to IDLE.
- DIV:
  - Restoring division on magnitudes: |A|,|B| for DIV, raw A,B for DIVU.
  - One quotient bit per cycle, 32 cycles, then go to FIX.
- FIX:
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (DIV only).
  - Commit LO←quotient, HI←remainder, then return to IDLE.
- Divide by zero (B=0): same latency, no sign fix, commit HI←A latched, LO←32'hFFFF_FFFF.
- Signed overflow (DIV 0x8000_0000 / 0xFFFF_FFFF): LO=0x8000_0000, HI=0. This is the natural result of the magnitude path.
- HI_O/LO_O hold their previous values throughout an operation and update atomically at commit.
- MT_I=HI/LO writes A_I into HI/LO at the clock edge:
  - In IDLE: a plain write.
  - While busy: aborts the in-flight operation (state→IDLE, no commit), then performs the write on the same edge.
- Start while busy is ignored.
- Start and MT on the same edge in IDLE: MT write wins, start is ignored.
- MDOp_I=OFF with MDCTRL_I=1 is a no-op.

## Timing
- Start sampled at edge t. Busy_O=1, Ready_O=0 from edge t.
- Multiply: HI/LO valid and Ready_O=1 after edge t+MUL_LAT.
- Divide: 32 iteration edges plus one FIX edge. HI/LO valid and Ready_O=1 after edge t+33.
- MT write visible on HI_O/LO_O the cycle after the edge.
- Reset mid-operation immediately forces reset values. No partial commit.
- Operand inputs may change after edge t without effect.

## Configuration
- `MDU_DIV_EN` defined: full divider, the DIV and FIX states, and the iteration counter are compiled in.
- `MDU_DIV_EN` undefined:
  - DIV/DIVU starts are no-ops: Ready_O stays 1 and HI/LO are unchanged.
  - DIV/FIX logic is absent.
  - MULT/MULTU/MT behave identically.

## Test plan
- Reset, then MULT A=0xFFFF_FFFE (−2), B=3 → Busy 5 cycles; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; Ready returns 1.
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001 after MUL_LAT.
- DIV A=−7 (0xFFFF_FFF9), B=2 → 33 cycles later LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1); DIVU 7/2 → LO=3, HI=1.
- DIVU A=0x1234, B=0 → after 33 cycles HI=0x1234, LO=0xFFFF_FFFF.
- Start DIV, assert MT_I=HI with A_I=0xCAFE at cycle 10 → Ready_O=1 next cycle, HI=0xCAFE, LO unchanged, no later commit; second MDCTRL_I pulse during MUL busy is ignored.
- Assert rst_I mid-multiply → HI=LO=0, Ready_O=1 immediately; build without MDU_DIV_EN: DIV start leaves Ready_O=1, HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MDU_DIV_EN to build in the restoring divider; otherwise divide starts are ignored.
module mult_div_unit #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk_I,
    input  logic        rst_I,
    input  logic [2:0]  MDOp_I,
    input  logic        MDCTRL_I,
    input  logic [1:0]  MT_I,
    input  logic [31:0] A_I,
    input  logic [31:0] B_I,
    output logic [31:0] HI_O,
    output logic [31:0] LO_O,
    output logic        Ready_O,
    output logic        Busy_O
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [1:0] MT_HI    = 2'b01;
    localparam logic [1:0] MT_LO    = 2'b10;

    localparam int CW = $clog2(MUL_LAT + 33);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   prod_q;
    logic [63:0]   prod_d;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          ready_q;
    logic          busy_q;
    logic          is_mul;
    logic          mul_sgn;

    assign is_mul  = (MDOp_I == OP_MULT) || (MDOp_I == OP_MULTU);
    assign mul_sgn = (MDOp_I == OP_MULT);

    // Zero- or sign-extend to 64 bits so one multiplier serves both forms.
    always_comb begin
        prod_d = {{32{mul_sgn & A_I[31]}}, A_I} * {{32{mul_sgn & B_I[31]}}, B_I};
    end

`ifdef MDU_DIV_EN
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sdiv_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [32:0] sh_d;
    logic [32:0] diff_d;
    logic        is_div;
    logic        sdiv;

    assign is_div = (MDOp_I == OP_DIV) || (MDOp_I == OP_DIVU);
    assign sdiv   = (MDOp_I == OP_DIV);

    // quo_q doubles as the dividend shift register; its top bit feeds rem.
    always_comb begin
        sh_d   = {rem_q, quo_q[31]};
        diff_d = sh_d - {1'b0, dvs_q};
        if (!diff_d[32]) begin
            rem_d = diff_d[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = sh_d[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end
`endif

    always_ff @(posedge clk_I or posedge rst_I) begin
        if (rst_I) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef MDU_DIV_EN
            a_q     <= '0;
            b_q     <= '0;
            sdiv_q  <= 1'b0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
`endif
        end else if (MT_I == MT_HI || MT_I == MT_LO) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            if (MT_I == MT_HI) hi_q <= A_I;
            else               lo_q <= A_I;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MDCTRL_I && is_mul) begin
                        prod_q  <= prod_d;
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
`ifdef MDU_DIV_EN
                    else if (MDCTRL_I && is_div) begin
                        a_q     <= A_I;
                        b_q     <= B_I;
                        sdiv_q  <= sdiv;
                        dvs_q   <= (sdiv && B_I[31]) ? -B_I : B_I;
                        quo_q   <= (sdiv && A_I[31]) ? -A_I : A_I;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
`endif
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        hi_q    <= prod_q[63:32];
                        lo_q    <= prod_q[31:0];
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CW'(31)) state_q <= S_FIX;
                    else                  cnt_q   <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    if (b_q == '0) begin
                        hi_q <= a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= (sdiv_q && a_q[31]) ? -rem_q : rem_q;
                        lo_q <= (sdiv_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
                    end
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign HI_O    = hi_q;
    assign LO_O    = lo_q;
    assign Ready_O = ready_q;
    assign Busy_O  = busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, monitor checks each commit.
// Divide vectors run only when MDU_DIV_EN is defined; otherwise divide starts must be no-ops.
module tb_mult_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  MDOp_I = '0;
    logic        MDCTRL_I = 1'b0;
    logic [1:0]  MT_I = '0;
    logic [31:0] A_I = '0;
    logic [31:0] B_I = '0;
    logic [31:0] HI_O;
    logic [31:0] LO_O;
    logic        Ready_O;
    logic        Busy_O;

    mult_div_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk_I    (clk),
        .rst_I    (rst),
        .MDOp_I   (MDOp_I),
        .MDCTRL_I (MDCTRL_I),
        .MT_I     (MT_I),
        .A_I      (A_I),
        .B_I      (B_I),
        .HI_O     (HI_O),
        .LO_O     (LO_O),
        .Ready_O  (Ready_O),
        .Busy_O   (Busy_O)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          busy_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(string n, logic [31:0] h, logic [31:0] l, int lat);
        sb.push_back('{hi: h, lo: l, lat: lat, name: n});
        m_hi = h;
        m_lo = l;
    endtask

    task automatic start(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        MDOp_I   = op;
        MDCTRL_I = 1'b1;
        A_I      = a;
        B_I      = b;
        @(negedge clk);
        MDCTRL_I = 1'b0;
        MDOp_I   = 3'b000;
        A_I      = $urandom;
        B_I      = $urandom;
    endtask

    task automatic mt(logic [1:0] sel, logic [31:0] a);
        @(negedge clk);
        MT_I = sel;
        A_I  = a;
        @(negedge clk);
        MT_I = 2'b00;
    endtask

    task automatic drain(int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every return of Ready_O to 1 must match the oldest expectation.
    always @(negedge clk) begin
        chk("busy_vs_ready", {31'b0, Busy_O}, {31'b0, ~Ready_O});
        if (Ready_O !== 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit",
                         HI_O, LO_O);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".hi"}, HI_O, e.hi);
                chk({e.name, ".lo"}, LO_O, e.lo);
                if (e.lat >= 0) chk({e.name, ".lat"}, busy_cnt, e.lat);
            end
            busy_cnt = 0;
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.hi", HI_O, 32'h0);
        chk("rst.lo", LO_O, 32'h0);
        chk("rst.ready", {31'b0, Ready_O}, 32'h1);
        chk("rst.busy", {31'b0, Busy_O}, 32'h0);

        push("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
        start(3'b001, 32'hFFFF_FFFE, 32'h3);
        drain(20);
        push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        start(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain(20);
        push("mult_min_sq", 32'h4000_0000, 32'h0, MUL_LAT);
        start(3'b001, 32'h8000_0000, 32'h8000_0000);
        drain(20);
        push("multu_2x", 32'h1, 32'h0, MUL_LAT);
        start(3'b010, 32'h8000_0000, 32'h2);
        drain(20);
        push("mult_m1sq", 32'h0, 32'h1, MUL_LAT);
        start(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain(20);

        push("mult_6x7", 32'h0, 32'h2A, MUL_LAT);
        start(3'b001, 32'h6, 32'h7);
        start(3'b010, 32'h1, 32'h1);
        drain(20);

        mt(2'b01, 32'h1111);
        chk("mthi.hi", HI_O, 32'h1111);
        chk("mthi.lo", LO_O, m_lo);
        mt(2'b10, 32'h2222);
        chk("mtlo.hi", HI_O, 32'h1111);
        chk("mtlo.lo", LO_O, 32'h2222);
        m_hi = 32'h1111;

        @(negedge clk);
        MDOp_I = 3'b001;
        MDCTRL_I = 1'b1;
        MT_I = 2'b10;
        A_I = 32'h3333;
        B_I = 32'h5;
        @(negedge clk);
        MDOp_I = 3'b000;
        MDCTRL_I = 1'b0;
        MT_I = 2'b00;
        chk("mt_vs_start.lo", LO_O, 32'h3333);
        chk("mt_vs_start.ready", {31'b0, Ready_O}, 32'h1);
        @(negedge clk);
        chk("mt_vs_start.ready2", {31'b0, Ready_O}, 32'h1);
        m_lo = 32'h3333;

        start(3'b000, 32'h9, 32'h9);
        chk("off.ready", {31'b0, Ready_O}, 32'h1);
        chk("off.hi", HI_O, m_hi);

        start(3'b001, 32'h10, 32'h10);
        push("mul_abort", 32'hBEEF, m_lo, 2);
        mt(2'b01, 32'hBEEF);
        repeat (10) @(negedge clk);
        drain(5);
        chk("mul_abort.hold", HI_O, 32'hBEEF);

`ifdef MDU_DIV_EN
        push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        start(3'b011, 32'hFFFF_FFF9, 32'h2);
        drain(50);
        push("divu_7_2", 32'h1, 32'h3, DIV_LAT);
        start(3'b100, 32'h7, 32'h2);
        drain(50);
        push("div_7_m2", 32'h1, 32'hFFFF_FFFD, DIV_LAT);
        start(3'b011, 32'h7, 32'hFFFF_FFFE);
        drain(50);
        push("divu_by0", 32'h1234, 32'hFFFF_FFFF, DIV_LAT);
        start(3'b100, 32'h1234, 32'h0);
        drain(50);
        push("div_m7_by0", 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);
        start(3'b011, 32'hFFFF_FFF9, 32'h0);
        drain(50);
        push("div_ovf", 32'h0, 32'h8000_0000, DIV_LAT);
        start(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        drain(50);

        start(3'b011, 32'd100, 32'd3);
        repeat (8) @(negedge clk);
        push("div_abort", 32'hCAFE, m_lo, 10);
        mt(2'b01, 32'hCAFE);
        repeat (40) @(negedge clk);
        drain(5);
        chk("div_abort.hi", HI_O, 32'hCAFE);
        chk("div_abort.lo", LO_O, m_lo);
`else
        start(3'b011, 32'h7, 32'h2);
        chk("nodiv.ready", {31'b0, Ready_O}, 32'h1);
        @(negedge clk);
        chk("nodiv.ready2", {31'b0, Ready_O}, 32'h1);
        start(3'b100, 32'h1234, 32'h0);
        repeat (DIV_LAT + 2) @(negedge clk);
        chk("nodiv.hi", HI_O, m_hi);
        chk("nodiv.lo", LO_O, m_lo);
        chk("nodiv.ready3", {31'b0, Ready_O}, 32'h1);
`endif

        push("rst_mid_mul", 32'h0, 32'h0, -1);
        start(3'b001, 32'h1234, 32'h5678);
        rst = 1'b1;
        #1;
        chk("rst_mid.hi", HI_O, 32'h0);
        chk("rst_mid.lo", LO_O, 32'h0);
        chk("rst_mid.ready", {31'b0, Ready_O}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        drain(5);
        repeat (MUL_LAT + 3) @(negedge clk);
        chk("rst_mid.nocommit", LO_O, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
